// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, FSM encoding and request entry for the memory responder
//
// Purpose: constants and types shared by mem_responder and mem_req_fifo.
// Contents: MEM_* widths, LINE_BEATS, state encoding, request-entry struct.
package mem_if_pkg;

  localparam int MEM_DATA_W = 128;
  localparam int MEM_ADDR_W = 24;
  localparam int MEM_TAG_W  = 5;
  localparam int LINE_BEATS = 4;
  localparam int BEAT_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RWAIT = 2'd2,
    RRESP = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic                  rw;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_TAG_W-1:0]  tag;
  } mem_req_entry_t;

  localparam int REQ_ENTRY_W = $bits(mem_req_entry_t);

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - synchronous request FIFO with full/empty flags
//
// Purpose: holds pending line requests in arrival order.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     enqueue (ignored when full)
//   pop, pop_data       dequeue (ignored when empty); pop_data shows the head
//   full, empty         occupancy flags
module mem_req_fifo
  import mem_if_pkg::*;
#(
  parameter int WIDTH = REQ_ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  // A full FIFO refuses pushes even when it pops in the same cycle (no bypass).
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = slots_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - line-based memory responder with fixed read latency
//
// Purpose: accepts tagged line read/write requests, absorbs 4 write beats per
// write line, and returns 4 tagged read beats LATENCY cycles after dispatch.
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   mem_req_valid/ready/rw/addr/tag     request channel
//   mem_req_data_valid/ready/bits/mask/offset   write-beat channel
//   mem_resp_valid/tag/data             read-beat channel (no backpressure)
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int MEM_DATA_BITS = MEM_DATA_W,
  parameter int MEM_ADDR_BITS = MEM_ADDR_W,
  parameter int MEM_TAG_BITS  = MEM_TAG_W,
  parameter int LINE_IDX_BITS = 10,
  parameter int LATENCY       = 4,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_valid,
  output logic                       mem_req_ready,
  input  logic                       mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
  input  logic                       mem_req_data_valid,
  output logic                       mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic [1:0]                 mem_req_data_offset,
  output logic                       mem_resp_valid,
  output logic [MEM_TAG_BITS-1:0]    mem_resp_tag,
  output logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

  localparam int RAM_IDX_W = LINE_IDX_BITS + BEAT_IDX_W;
  localparam int RAM_DEPTH = 1 << RAM_IDX_W;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MASK_W    = MEM_DATA_BITS / 8;

  logic [MEM_DATA_BITS-1:0] ram [RAM_DEPTH];

  mem_state_e               state_q, state_d;
  logic [BEAT_IDX_W-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [MEM_TAG_BITS-1:0]  resp_tag_q, resp_tag_d;
  logic [MEM_DATA_BITS-1:0] resp_data_q, resp_data_d;

  mem_req_entry_t           push_entry;
  mem_req_entry_t           head;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;

  logic [LINE_IDX_BITS-1:0] head_idx;
  logic [BEAT_IDX_W-1:0]    beat_inc;
  logic [BEAT_IDX_W-1:0]    rd_beat;
  logic [RAM_IDX_W-1:0]     rd_idx;
  logic [RAM_IDX_W-1:0]     wr_idx;
  logic                     last_beat;
  logic                     wr_fire;
  logic                     unused_addr_hi;

  // Ready is forced low while reset is held, independent of FIFO state.
  assign mem_req_ready = reset && !fifo_full;
  assign fifo_push     = mem_req_valid && mem_req_ready;
  assign push_entry    = '{rw: mem_req_rw, addr: mem_req_addr, tag: mem_req_tag};

  mem_req_fifo #(
    .WIDTH (REQ_ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Address bits above the line index alias onto the same storage.
  assign head_idx       = head.addr[LINE_IDX_BITS-1:0];
  assign unused_addr_hi = ^head.addr[MEM_ADDR_W-1:LINE_IDX_BITS];
  assign beat_inc       = beat_q + 1'b1;
  assign last_beat      = (beat_q == BEAT_IDX_W'(LINE_BEATS - 1));
  assign wr_fire        = (state_q == WDATA) && mem_req_data_valid;
  // Write placement follows the offset port, not the accepted-beat count.
  assign wr_idx         = {head_idx, mem_req_data_offset};
  assign rd_beat        = (state_q == RRESP) ? beat_inc : '0;
  assign rd_idx         = {head_idx, rd_beat};

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = head.rw ? WDATA : RWAIT;
      WDATA:   if (mem_req_data_valid && last_beat) state_d = IDLE;
      RWAIT:   if (wait_cnt_q == '0) state_d = RRESP;
      RRESP:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. Response outputs are registered, so the first
  // beat is loaded on the edge that leaves RWAIT and each later beat on the
  // following RRESP edges; beat_q names the beat currently on the port.
  always_comb begin
    beat_d             = beat_q;
    wait_cnt_d         = wait_cnt_q;
    resp_valid_d       = 1'b0;
    resp_tag_d         = '0;
    resp_data_d        = '0;
    fifo_pop           = 1'b0;
    mem_req_data_ready = (state_q == WDATA);
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (!fifo_empty && !head.rw) wait_cnt_d = CNT_W'(LATENCY - 1);
      end
      WDATA: begin
        if (mem_req_data_valid) begin
          beat_d   = beat_inc;
          fifo_pop = last_beat;
        end
      end
      RWAIT: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end else begin
          beat_d       = '0;
          resp_valid_d = 1'b1;
          resp_tag_d   = head.tag;
          resp_data_d  = ram[rd_idx];
        end
      end
      RRESP: begin
        if (last_beat) begin
          beat_d   = '0;
          fifo_pop = 1'b1;
        end else begin
          beat_d       = beat_inc;
          resp_valid_d = 1'b1;
          resp_tag_d   = head.tag;
          resp_data_d  = ram[rd_idx];
        end
      end
      default: beat_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Storage is never reset; byte-enabled writes only while absorbing a line.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (mem_req_data_mask[b]) ram[wr_idx][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
      end
    end
  end

  assign mem_resp_valid = resp_valid_q;
  assign mem_resp_tag   = resp_tag_q;
  assign mem_resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_ready;
  logic         mem_req_rw = 1'b0;
  logic [23:0]  mem_req_addr = '0;
  logic [4:0]   mem_req_tag = '0;
  logic         mem_req_data_valid = 1'b0;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits = '0;
  logic [15:0]  mem_req_data_mask = '0;
  logic [1:0]   mem_req_data_offset = '0;
  logic         mem_resp_valid;
  logic [4:0]   mem_resp_tag;
  logic [127:0] mem_resp_data;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk                 (clk),
    .reset               (reset),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_rw          (mem_req_rw),
    .mem_req_addr        (mem_req_addr),
    .mem_req_tag         (mem_req_tag),
    .mem_req_data_valid  (mem_req_data_valid),
    .mem_req_data_ready  (mem_req_data_ready),
    .mem_req_data_bits   (mem_req_data_bits),
    .mem_req_data_mask   (mem_req_data_mask),
    .mem_req_data_offset (mem_req_data_offset),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_tag        (mem_resp_tag),
    .mem_resp_data       (mem_resp_data)
  );

  typedef struct {
    logic [4:0]   tag;
    logic [127:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [127:0] mdl [int];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           beats_seen = 0;
  logic [23:0]  cur_wline = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  function automatic logic [127:0] pat(input int line, input int b);
    logic [31:0] w;
    w = {8'hA0 | 8'(b), 8'h5A, 16'(line)};
    return {w, w + 32'h1111_0000, w + 32'h2222_0000, w + 32'h3333_0000};
  endfunction

  function automatic int key(input logic [23:0] addr, input int b);
    return int'({addr[9:0], 2'(b)});
  endfunction

  // Monitor: every presented beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset && mem_resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp actual=tag %0d data %h required=no beat", mem_resp_tag, mem_resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_tag", 128'(mem_resp_tag), 128'(mon_e.tag));
        chk("resp_data", mem_resp_data, mon_e.data);
      end
      beats_seen++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, e = cyc of that edge.
  task automatic issue(input logic rw, input logic [23:0] addr, input logic [4:0] tag, output int e);
    int   n = 0;
    logic acc = 1'b0;
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = addr;
    mem_req_tag   = tag;
    do begin
      @(negedge clk);
      acc = mem_req_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    #1;
    mem_req_valid = 1'b0;
    e = cyc;
    if (!acc) timeout("req_accept");
  endtask

  task automatic rd(input logic [23:0] addr, input logic [4:0] tag, output int e);
    exp_t x;
    issue(1'b0, addr, tag, e);
    for (int b = 0; b < 4; b++) begin
      x.tag  = tag;
      x.data = mdl[key(addr, b)];
      exp_q.push_back(x);
    end
  endtask

  task automatic wr_line(input logic [23:0] addr, input logic [4:0] tag);
    int e;
    cur_wline = addr;
    issue(1'b1, addr, tag, e);
  endtask

  task automatic wr_beat(input logic [1:0] off, input logic [127:0] data, input logic [15:0] mask);
    int           n = 0;
    logic         acc = 1'b0;
    logic [127:0] cur;
    int           k;
    mem_req_data_valid  = 1'b1;
    mem_req_data_offset = off;
    mem_req_data_bits   = data;
    mem_req_data_mask   = mask;
    do begin
      @(negedge clk);
      acc = mem_req_data_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    #1;
    mem_req_data_valid = 1'b0;
    if (!acc) begin
      timeout("data_accept");
    end else begin
      k   = key(cur_wline, int'(off));
      cur = mdl.exists(k) ? mdl[k] : '0;
      for (int i = 0; i < 16; i++) if (mask[i]) cur[i*8 +: 8] = data[i*8 +: 8];
      mdl[k] = cur;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lat_check(input int e);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (mem_resp_valid) break;
      n++;
    end
    if (n >= 50) timeout("first_beat");
    else chk("first_beat_latency", 128'(cyc - e), 128'd5);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
    gap(3);
  endtask

  int e, e2, b0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(mem_req_ready), 128'd0);
    chk("rst_data_ready", 128'(mem_req_data_ready), 128'd0);
    chk("rst_resp_valid", 128'(mem_resp_valid), 128'd0);
    chk("rst_resp_tag", 128'(mem_resp_tag), 128'd0);
    chk("rst_resp_data", mem_resp_data, 128'd0);
    reset = 1'b1;
    #1;
    chk("req_ready_after_rst", 128'(mem_req_ready), 128'd1);
    gap(1);

    // Preload lines 0x10, 0x20 in order and 0x000 with reversed offsets
    wr_line(24'h10, 5'd0);
    for (int b = 0; b < 4; b++) wr_beat(2'(b), pat(16'h10, b), 16'hFFFF);
    wr_line(24'h20, 5'd0);
    for (int b = 0; b < 4; b++) wr_beat(2'(b), pat(16'h20, b), 16'hFFFF);
    wr_line(24'h000, 5'd0);
    for (int b = 3; b >= 0; b--) wr_beat(2'(b), pat(16'h0, b), 16'hFFFF);

    // Single read, latency and beat order
    rd(24'h10, 5'd3, e);
    lat_check(e);
    drain();

    // Masked write: only low 4 bytes of beat 2 change
    wr_line(24'h20, 5'd5);
    wr_beat(2'd0, {128{1'b1}}, 16'h0000);
    wr_beat(2'd1, {128{1'b1}}, 16'h0000);
    wr_beat(2'd2, {128{1'b1}}, 16'h000F);
    wr_beat(2'd3, {128{1'b1}}, 16'h0000);
    rd(24'h20, 5'd7, e);
    drain();

    // Four back-to-back reads fill the queue
    b0 = beats_seen;
    rd(24'h10, 5'd1, e);
    rd(24'h20, 5'd2, e);
    rd(24'h000, 5'd3, e);
    rd(24'h10, 5'd4, e);
    chk("req_ready_full", 128'(mem_req_ready), 128'd0);
    begin
      int n = 0;
      while (!mem_req_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("req_ready_after_pop", 128'(mem_req_ready), 128'd1);
    end
    drain();
    chk("burst_beat_count", 128'(beats_seen - b0), 128'd16);

    // Gapped write data, offsets out of order, then a stray beat while idle
    wr_line(24'h30, 5'd6);
    wr_beat(2'd1, pat(16'h30, 1), 16'hFFFF);
    gap(1);
    wr_beat(2'd3, pat(16'h30, 3), 16'hFFFF);
    gap(2);
    wr_beat(2'd0, pat(16'h30, 0), 16'hFFFF);
    wr_beat(2'd2, pat(16'h30, 2), 16'hFFFF);
    chk("data_ready_after_line", 128'(mem_req_data_ready), 128'd0);
    mem_req_data_valid  = 1'b1;
    mem_req_data_offset = 2'd0;
    mem_req_data_bits   = '0;
    mem_req_data_mask   = 16'hFFFF;
    gap(3);
    chk("data_ready_idle", 128'(mem_req_data_ready), 128'd0);
    mem_req_data_valid = 1'b0;
    rd(24'h30, 5'd8, e);
    drain();

    // Reset during beat 2 of a read with a second read queued behind it
    b0 = beats_seen;
    rd(24'h10, 5'd9, e);
    issue(1'b0, 24'h20, 5'd10, e2);
    begin
      int n = 0;
      while (n < 60) begin
        @(posedge clk);
        #1;
        if (mem_resp_valid && beats_seen == b0 + 2) break;
        n++;
      end
      if (n >= 60) timeout("reach_beat2");
    end
    reset = 1'b0;
    #1;
    chk("abort_resp_valid", 128'(mem_resp_valid), 128'd0);
    chk("abort_req_ready", 128'(mem_req_ready), 128'd0);
    exp_q.delete();
    gap(2);
    reset = 1'b1;
    #1;
    chk("abort_req_ready_release", 128'(mem_req_ready), 128'd1);
    gap(20);
    chk("no_stale_beats", 128'(beats_seen - b0), 128'd2);
    rd(24'h10, 5'd11, e);
    lat_check(e);
    drain();

    // Address wrap: 0x400 aliases line 0x000
    issue(1'b0, 24'h400, 5'd12, e);
    for (int b = 0; b < 4; b++) exp_q.push_back('{tag: 5'd12, data: pat(16'h0, b)});
    issue(1'b0, 24'h000, 5'd13, e);
    for (int b = 0; b < 4; b++) exp_q.push_back('{tag: 5'd13, data: pat(16'h0, b)});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
